// File: rtl/aes256_round_key_store.sv
// AES-256 round key store: captures the 15 round keys streamed by the key
// expander and serves them through a registered random-access read port
// with forward or reverse round indexing.
module aes256_round_key_store #(
  parameter int NUM_KEYS = 15,
  parameter int KEY_W    = 128,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             key_in_valid,
  input  logic [KEY_W-1:0] key_in,
  output logic             keys_ready,
  output logic             loading,
  input  logic             rd_en,
  input  logic             rd_reverse,
  input  logic [IDX_W-1:0] rd_round,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_data,
  output logic             rd_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] wr_ptr_next;
  logic             wr_en;
  logic             rd_accept;
  logic [IDX_W-1:0] rd_idx;

  logic [KEY_W-1:0] key_mem [NUM_KEYS];

  // State and write pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      wr_ptr <= '0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr_next;
    end
  end

  // Next-state logic; load_start always takes priority over an incoming key
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    wr_en       = 1'b0;
    case (state)
      EMPTY: begin
        if (load_start) begin
          state_next  = LOADING;
          wr_ptr_next = '0;
        end
      end
      LOADING: begin
        if (load_start) begin
          wr_ptr_next = '0;
        end else if (key_in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_IDX) begin
            state_next  = READY;
            wr_ptr_next = '0;
          end else begin
            wr_ptr_next = wr_ptr + 1'b1;
          end
        end
      end
      READY: begin
        if (load_start) begin
          state_next  = LOADING;
          wr_ptr_next = '0;
        end
      end
      default: begin
        state_next  = EMPTY;
        wr_ptr_next = '0;
      end
    endcase
  end

  // Status outputs decoded from registered state only
  always_comb begin
    loading    = (state == LOADING);
    keys_ready = (state == READY);
  end

  // Key register file; contents are don't-care until a full load completes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_ptr] <= key_in;
    end
  end

  // Read acceptance and effective index; reverse math only matters when accepted
  always_comb begin
    rd_accept = rd_en && (state == READY) && (rd_round <= LAST_IDX);
    rd_idx    = rd_reverse ? (LAST_IDX - rd_round) : rd_round;
  end

  // Registered read port with one-cycle latency
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      rd_err   <= rd_en && !rd_accept;
      rd_data  <= rd_accept ? key_mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_aes256_round_key_store.sv
// Testbench for aes256_round_key_store: behavioural model plus read scoreboard.
module tb_aes256_round_key_store;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_start;
  logic         key_in_valid;
  logic [127:0] key_in;
  logic         keys_ready;
  logic         loading;
  logic         rd_en;
  logic         rd_reverse;
  logic [3:0]   rd_round;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         rd_err;

  aes256_round_key_store #(
    .NUM_KEYS(15),
    .KEY_W   (128),
    .IDX_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .key_in_valid(key_in_valid),
    .key_in      (key_in),
    .keys_ready  (keys_ready),
    .loading     (loading),
    .rd_en       (rd_en),
    .rd_reverse  (rd_reverse),
    .rd_round    (rd_round),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_err      (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic         e;
    logic [127:0] d;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic         due = 1'b0;

  // Model: 0 = empty, 1 = loading, 2 = ready
  int           mdl_st = 0;
  int           mdl_ptr = 0;
  logic [127:0] mdl_keys [15];
  logic [127:0] fips [15];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t exp_read(input logic rev, input logic [3:0] rnd);
    exp_t r;
    int   idx;
    if (mdl_st == 2 && rnd <= 4'd14) begin
      idx = rev ? (14 - int'(rnd)) : int'(rnd);
      r.v = 1'b1;
      r.e = 1'b0;
      r.d = mdl_keys[idx];
    end else begin
      r.v = 1'b0;
      r.e = 1'b1;
      r.d = '0;
    end
    return r;
  endfunction

  // One cycle of stimulus; expectations are queued before the model advances
  task automatic drive(input logic ld, input logic kv, input logic [127:0] k,
                       input logic re, input logic rev, input logic [3:0] rnd);
    load_start   = ld;
    key_in_valid = kv;
    key_in       = k;
    rd_en        = re;
    rd_reverse   = rev;
    rd_round     = rnd;
    if (re) sb.push_back(exp_read(rev, rnd));
    if (ld) begin
      mdl_st  = 1;
      mdl_ptr = 0;
    end else if (mdl_st == 1 && kv) begin
      mdl_keys[mdl_ptr] = k;
      if (mdl_ptr == 14) begin
        mdl_st  = 2;
        mdl_ptr = 0;
      end else begin
        mdl_ptr++;
      end
    end
    @(negedge clk);
    check("loading", loading, mdl_st == 1);
    check("keys_ready", keys_ready, mdl_st == 2);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic rev, input logic [3:0] rnd);
    drive(1'b0, 1'b0, '0, 1'b1, rev, rnd);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Read-result monitor: compares DUT read outputs against queued expectations
  always @(posedge clk) due <= rd_en && !reset;

  always @(negedge clk) begin
    exp_t e;
    if (due) begin
      check("sb_pending", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rd_valid", rd_valid, e.v);
        check("rd_err", rd_err, e.e);
        check("rd_data", rd_data, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    fips = '{
      128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
      128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
      128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
      128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
      128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
      128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
      128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
      128'h24fc79ccbf0979e9371ac23c6d68de36};

    reset = 1'b1; load_start = 1'b0; key_in_valid = 1'b0; key_in = '0;
    rd_en = 1'b0; rd_reverse = 1'b0; rd_round = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_loading", loading, 1'b0);
    check("rst_keys_ready", keys_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    check("rst_rd_data", rd_data, '0);

    // FIPS-197 load on consecutive cycles, then forward and reverse reads
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, fips[i], 1'b0, 1'b0, 4'd0);
    check("ready_after_15th", keys_ready, 1'b1);
    rd(1'b0, 4'd0);
    rd(1'b0, 4'd1);
    rd(1'b0, 4'd2);
    rd(1'b0, 4'd14);
    rd(1'b1, 4'd0);
    rd(1'b1, 4'd14);
    idle();
    check("fips_r14_ref", mdl_keys[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Keys offered while READY are ignored
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '1, 1'b0, 1'b0, 4'd0);
    rd(1'b0, 4'd7);
    idle();
    check("key7_unchanged", mdl_keys[7], fips[7]);

    // Gapped load with fresh keys, full forward sweep and out-of-range reads
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) begin
      if (i == 6) repeat (3) idle();
      drive(1'b0, 1'b1, rnd128(), 1'b0, 1'b0, 4'd0);
    end
    for (int i = 0; i < 15; i++) rd(1'b0, 4'(i));
    rd(1'b0, 4'd15);
    rd(1'b1, 4'd15);
    rd(1'b1, 4'd9);
    idle();

    // Reload collides with a read, restart mid-load, reject read at wr_ptr=8
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 4'd3);
    rd(1'b0, 4'd3);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, rnd128(), 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, '1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, rnd128(), 1'b0, 1'b0, 4'd0);
    rd(1'b0, 4'd2);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, rnd128(), 1'b0, 1'b0, 4'd0);
    rd(1'b0, 4'd0);
    rd(1'b0, 4'd14);
    rd(1'b1, 4'd3);
    idle();

    // Reset while loading at wr_ptr=10
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, rnd128(), 1'b0, 1'b0, 4'd0);
    reset = 1'b1; load_start = 1'b0; key_in_valid = 1'b1; rd_en = 1'b1; rd_round = 4'd0;
    mdl_st = 0; mdl_ptr = 0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_loading", loading, 1'b0);
    check("mid_rst_keys_ready", keys_ready, 1'b0);
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_rd_err", rd_err, 1'b0);
    check("mid_rst_rd_data", rd_data, '0);
    drive(1'b0, 1'b1, rnd128(), 1'b1, 1'b0, 4'd0);
    idle();
    idle();
    check("sb_drain", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
